// File: rtl/result_scoreboard.sv
// Self-check scoreboard: walks a loadable table of expected dm/rf results once the core signals done.
// Optional per-entry compare mask enabled by defining SCOREBOARD_MASK_EN.
module result_scoreboard #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int N_CHECKS    = 16,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IDXW       = $clog2(N_CHECKS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            arm,
  input  logic            done,
  input  logic            exp_we,
  input  logic [IDXW-1:0] exp_idx,
  input  logic            exp_sel,
  input  logic [AW-1:0]   exp_addr,
  input  logic [DW-1:0]   exp_data,
`ifdef SCOREBOARD_MASK_EN
  input  logic [DW-1:0]   exp_mask,
`endif
  input  logic [IDXW:0]   n_checks,
  output logic            rd_en,
  output logic            rd_sel,
  output logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   rd_data,
  output logic            busy,
  output logic            check_done,
  output logic            pass,
  output logic [IDXW:0]   fail_count,
  output logic [IDXW-1:0] first_fail_idx,
  output logic [DW-1:0]   first_fail_data,
  output logic            timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {IDLE, WAIT_DONE, ISSUE, COMPARE, FINISH} state_t;

  state_t state, state_nxt;

  logic            tbl_sel  [N_CHECKS];
  logic [AW-1:0]   tbl_addr [N_CHECKS];
  logic [DW-1:0]   tbl_data [N_CHECKS];
`ifdef SCOREBOARD_MASK_EN
  logic [DW-1:0]   tbl_mask [N_CHECKS];
`endif

  logic [IDXW-1:0] idx;
  logic [IDXW:0]   n_q;
  logic [TW-1:0]   tmo;
  logic            rd_sel_q;
  logic [AW-1:0]   rd_addr_q;
  logic            idle_like;
  logic            tmo_hit;
  logic            last;
  logic            mism;

  assign idle_like = (state == IDLE) || (state == FINISH);
  assign tmo_hit   = (tmo == TW'(TIMEOUT_CYC - 1));
  assign last      = ({1'b0, idx} == (n_q - (IDXW+1)'(1)));

  always_comb begin
    mism = 1'b0;
`ifdef SCOREBOARD_MASK_EN
    mism = (((rd_data ^ tbl_data[idx]) & tbl_mask[idx]) != '0);
`else
    mism = (rd_data != tbl_data[idx]);
`endif
  end

  // Table is deliberately outside reset so expectations survive an aborted run.
  always_ff @(posedge clk) begin
    if (exp_we && idle_like) begin
      tbl_sel[exp_idx]  <= exp_sel;
      tbl_addr[exp_idx] <= exp_addr;
      tbl_data[exp_idx] <= exp_data;
`ifdef SCOREBOARD_MASK_EN
      tbl_mask[exp_idx] <= exp_mask;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH: if (arm) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (done)         state_nxt = (n_q == '0) ? FINISH : ISSUE;
        else if (tmo_hit) state_nxt = FINISH;
      end
      ISSUE:    state_nxt = COMPARE;
      COMPARE:  state_nxt = last ? FINISH : ISSUE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en      = (state == ISSUE);
    rd_sel     = rd_sel_q;
    rd_addr    = rd_addr_q;
    busy       = (state == WAIT_DONE) || (state == ISSUE) || (state == COMPARE);
    check_done = (state == FINISH);
    pass       = (state == FINISH) && (fail_count == '0) && !timeout;
    if (state == ISSUE) begin
      rd_sel  = tbl_sel[idx];
      rd_addr = tbl_addr[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx             <= '0;
      n_q             <= '0;
      tmo             <= '0;
      rd_sel_q        <= 1'b0;
      rd_addr_q       <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      timeout         <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (arm) begin
            n_q             <= (n_checks > (IDXW+1)'(N_CHECKS)) ? (IDXW+1)'(N_CHECKS) : n_checks;
            idx             <= '0;
            tmo             <= '0;
            fail_count      <= '0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
            timeout         <= 1'b0;
          end
        end
        WAIT_DONE: begin
          tmo <= tmo + TW'(1);
          idx <= '0;
          if (!done && tmo_hit) timeout <= 1'b1;
        end
        ISSUE: begin
          rd_sel_q  <= tbl_sel[idx];
          rd_addr_q <= tbl_addr[idx];
        end
        COMPARE: begin
          if (mism) begin
            if (fail_count != (IDXW+1)'(N_CHECKS)) fail_count <= fail_count + (IDXW+1)'(1);
            if (fail_count == '0) begin
              first_fail_idx  <= idx;
              first_fail_data <= rd_data;
            end
          end
          if (!last) idx <= idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
